// File: rtl/inst_loader_pkg.sv
// inst_loader_pkg: shared instruction width defaults and the loader state encoding.
`ifndef INST_WIDTH
`define INST_WIDTH 32
`endif
`ifndef IM_ADDR_WIDTH
`define IM_ADDR_WIDTH 4
`endif
package inst_loader_pkg;
    typedef enum logic [1:0] {IDLE, LOAD, EXEC, DONE} state_t;
endpackage

// File: rtl/inst_buf.sv
// inst_buf: program buffer of 2**AW-1 words with write/read pointers and occupancy count.
`ifndef INST_WIDTH
`define INST_WIDTH 32
`endif
`ifndef IM_ADDR_WIDTH
`define IM_ADDR_WIDTH 4
`endif
module inst_buf #(
    parameter int W  = `INST_WIDTH,
    parameter int AW = `IM_ADDR_WIDTH
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          wr,
    input  logic [W-1:0]  din,
    input  logic          rd,
    input  logic          clr,
    output logic [W-1:0]  dout,
    output logic [AW-1:0] count,
    output logic          full
);
    localparam int DEPTH = 2**AW - 1;
    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    assign full = count == DEPTH[AW-1:0];
    assign dout = mem[rd_ptr];
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr) begin
                wr_ptr <= wr_ptr + 1'b1;
                count  <= count + 1'b1;
            end
            if (rd) rd_ptr <= rd_ptr + 1'b1;
        end
    end
    // storage is deliberately left unreset; the count gates every read
    always_ff @(posedge clk) begin
        if (wr) mem[wr_ptr] <= din;
    end
endmodule

// File: rtl/inst_loader.sv
// inst_loader: buffers host instruction words and streams them to the PE instruction memory,
// then holds busy through the downstream replay window before pulsing done.
`ifndef INST_WIDTH
`define INST_WIDTH 32
`endif
`ifndef IM_ADDR_WIDTH
`define IM_ADDR_WIDTH 4
`endif
module inst_loader
    import inst_loader_pkg::*;
#(
    parameter int INST_WIDTH    = `INST_WIDTH,
    parameter int IM_ADDR_WIDTH = `IM_ADDR_WIDTH
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wr_en,
    input  logic [INST_WIDTH-1:0]    wr_inst,
    input  logic                     start,
    output logic                     full,
    output logic [IM_ADDR_WIDTH-1:0] count,
    output logic                     busy,
    output logic                     done,
    output logic                     valid,
    output logic [INST_WIDTH-1:0]    inst_out
);
    state_t                  state, nxt;
    logic [IM_ADDR_WIDTH:0]  k, k_nxt, n;
    logic                    emit, clr, wr, done_nxt;
    logic [INST_WIDTH-1:0]   rd_data;
    assign busy = state != IDLE;
    assign n    = {1'b0, count};
    // zero words are no-ops downstream, so they never occupy a slot
    assign wr   = wr_en & ~full & ~busy & ~start & (|wr_inst);
    inst_buf #(.W(INST_WIDTH), .AW(IM_ADDR_WIDTH)) u_buf (
        .clk   (clk),
        .rst_n (rst_n),
        .wr    (wr),
        .din   (wr_inst),
        .rd    (emit),
        .clr   (clr),
        .dout  (rd_data),
        .count (count),
        .full  (full)
    );
    always_comb begin
        nxt      = state;
        k_nxt    = k;
        emit     = 1'b0;
        done_nxt = 1'b0;
        clr      = 1'b0;
        case (state)
            IDLE: if (start) begin
                if (count != '0) begin
                    nxt   = LOAD;
                    emit  = 1'b1;
                    k_nxt = 1;
                end else done_nxt = 1'b1;
            end
            LOAD: if (k < n) begin
                emit  = 1'b1;
                k_nxt = k + 1'b1;
            end else begin
                nxt   = EXEC;
                k_nxt = '0;
            end
            // k counts N+2 execution cycles covering the replay window
            EXEC: if (k == n + 1'b1) begin
                nxt      = DONE;
                done_nxt = 1'b1;
            end else k_nxt = k + 1'b1;
            DONE: begin
                nxt   = IDLE;
                clr   = 1'b1;
                k_nxt = '0;
            end
            default: nxt = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            k        <= '0;
            valid    <= 1'b0;
            inst_out <= '0;
            done     <= 1'b0;
        end else begin
            state    <= nxt;
            k        <= k_nxt;
            valid    <= emit;
            inst_out <= emit ? rd_data : '0;
            done     <= done_nxt;
        end
    end
endmodule
